// File: rtl/calc_ctrl_fsm.sv
// calc_ctrl_fsm - keypad-to-ALU control FSM for the FPGA calculator.
//
// Builds BCD operands from digit keys, latches the operator, runs a
// start/done handshake with the ALU (with a timeout) and drives the value
// for the display.
//
// Parameters:
//   DIGITS      operand/display width in BCD digits (W = 4*DIGITS)
//   TIMEOUT_CYC maximum cycles in WAIT_ALU before ERROR (>= 1)
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   key_valid         key held (synchronised)
//   key_code[3:0]     0-9 digit, 10 '=', 11 AC, 12 '+', 13 '-', 14 '*', 15 '/'
//   alu_res[W-1:0]    ALU result, qualified by alu_done
//   alu_done          one-cycle ALU completion strobe
//   alu_err           ALU error qualifier, sampled with alu_done
//   num1, num2        operands to the ALU
//   operation[3:0]    latched operator code
//   alu_start         one-cycle start pulse (high while in START)
//   display[W-1:0]    registered display value
//   state_o[2:0]      current state (debug)
//   err               high while in ERROR
//
// Build option:
//   CALC_CHAIN_EN     an operator in ENTER2 with digits entered computes the
//                     pending operation first and continues in ENTER2.
module calc_ctrl_fsm #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic [4*DIGITS-1:0] alu_res,
  input  logic                alu_done,
  input  logic                alu_err,
  output logic [4*DIGITS-1:0] num1,
  output logic [4*DIGITS-1:0] num2,
  output logic [3:0]          operation,
  output logic                alu_start,
  output logic [4*DIGITS-1:0] display,
  output logic [2:0]          state_o,
  output logic                err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0] KEY_EQ = 4'd10;
  localparam logic [3:0] KEY_AC = 4'd11;

  typedef enum logic [2:0] {
    ENTER1   = 3'd0,
    ENTER2   = 3'd1,
    START    = 3'd2,
    WAIT_ALU = 3'd3,
    SHOW     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    num1_q, num1_d;
  logic [W-1:0]    num2_q, num2_d;
  logic [CW-1:0]   cnt1_q, cnt1_d;
  logic [CW-1:0]   cnt2_q, cnt2_d;
  logic [3:0]      op_q, op_d;
  logic [W-1:0]    result_q, result_d;
  logic [W-1:0]    display_q, display_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            chain_q, chain_d;
  logic [3:0]      chain_op_q, chain_op_d;
  logic            alu_start_q, alu_start_d;
  logic            err_q, err_d;

  // Key edge detection: code latched on press, action one cycle after release.
  logic            kv_prev_q;
  logic            armed_q;
  logic [3:0]      key_q;
  logic            evt_q;

  logic            is_digit;
  logic            is_op;
  logic            clr_all;

  assign is_digit = (key_q <= 4'd9);
  assign is_op    = (key_q >= 4'd12);

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v,
                                            input logic [3:0]   d);
    return (v << 4) | W'(d);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ENTER1;
      num1_q      <= '0;
      num2_q      <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      op_q        <= '0;
      result_q    <= '0;
      display_q   <= '0;
      tmo_q       <= '0;
      chain_q     <= 1'b0;
      chain_op_q  <= '0;
      alu_start_q <= 1'b0;
      err_q       <= 1'b0;
      // Primed high so a key held through reset produces no rising edge;
      // armed_q low so its release is not acted on either.
      kv_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
      key_q       <= '0;
      evt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      op_q        <= op_d;
      result_q    <= result_d;
      display_q   <= display_d;
      tmo_q       <= tmo_d;
      chain_q     <= chain_d;
      chain_op_q  <= chain_op_d;
      alu_start_q <= alu_start_d;
      err_q       <= err_d;
      kv_prev_q   <= key_valid;
      evt_q       <= !key_valid && kv_prev_q && armed_q;
      if (key_valid && !kv_prev_q) begin
        key_q   <= key_code;
        armed_q <= 1'b1;
      end else if (!key_valid && kv_prev_q) begin
        armed_q <= 1'b0;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    op_d       = op_q;
    result_d   = result_q;
    tmo_d      = tmo_q;
    chain_d    = chain_q;
    chain_op_d = chain_op_q;
    clr_all    = 1'b0;

    unique case (state_q)
      ENTER1: begin
        if (evt_q) begin
          if (is_digit) begin
            if (cnt1_q != CW'(DIGITS)) begin
              num1_d = shift_in(num1_q, key_q);
              if (key_q != 4'd0 || cnt1_q != '0) cnt1_d = cnt1_q + CW'(1);
            end
          end else if (is_op) begin
            op_d    = key_q;
            num2_d  = '0;
            cnt2_d  = '0;
            state_d = ENTER2;
          end else if (key_q == KEY_AC) begin
            num1_d = '0;
            cnt1_d = '0;
          end
        end
      end

      ENTER2: begin
        if (evt_q) begin
          if (is_digit) begin
            if (cnt2_q != CW'(DIGITS)) begin
              num2_d = shift_in(num2_q, key_q);
              if (key_q != 4'd0 || cnt2_q != '0) cnt2_d = cnt2_q + CW'(1);
            end
          end else if (key_q == KEY_EQ) begin
            state_d = START;
          end else if (key_q == KEY_AC) begin
            clr_all = 1'b1;
          end else begin
`ifdef CALC_CHAIN_EN
            // Chained operator: compute now, apply the new operator on success.
            if (cnt2_q != '0) begin
              chain_d    = 1'b1;
              chain_op_d = key_q;
              state_d    = START;
            end else begin
              op_d = key_q;
            end
`else
            op_d = key_q;
`endif
          end
        end
      end

      START: begin
        tmo_d   = '0;
        state_d = WAIT_ALU;
      end

      WAIT_ALU: begin
        tmo_d = tmo_q + TW'(1);
        if (evt_q && key_q == KEY_AC) begin
          clr_all = 1'b1;
        end else if (alu_done) begin
          chain_d = 1'b0;
          if (alu_err) begin
            state_d = ERROR;
          end else begin
            result_d = alu_res;
            if (chain_q) begin
              num1_d  = alu_res;
              cnt1_d  = CW'(DIGITS);
              op_d    = chain_op_q;
              num2_d  = '0;
              cnt2_d  = '0;
              state_d = ENTER2;
            end else begin
              state_d = SHOW;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          // This is the TIMEOUT_CYC-th cycle in WAIT_ALU.
          chain_d = 1'b0;
          state_d = ERROR;
        end
      end

      SHOW: begin
        if (evt_q) begin
          if (is_digit) begin
            num1_d  = W'(key_q);
            cnt1_d  = (key_q != 4'd0) ? CW'(1) : '0;
            num2_d  = '0;
            cnt2_d  = '0;
            state_d = ENTER1;
          end else if (is_op) begin
            num1_d  = result_q;
            cnt1_d  = CW'(DIGITS);
            op_d    = key_q;
            num2_d  = '0;
            cnt2_d  = '0;
            state_d = ENTER2;
          end else if (key_q == KEY_AC) begin
            clr_all = 1'b1;
          end else begin
            num1_d  = result_q;
            cnt1_d  = CW'(DIGITS);
            state_d = START;
          end
        end
      end

      ERROR: begin
        if (evt_q && key_q == KEY_AC) clr_all = 1'b1;
      end

      default: state_d = ENTER1;
    endcase

    if (clr_all) begin
      num1_d   = '0;
      num2_d   = '0;
      cnt1_d   = '0;
      cnt2_d   = '0;
      op_d     = '0;
      result_d = '0;
      chain_d  = 1'b0;
      state_d  = ENTER1;
    end
  end

  // Registered outputs
  always_comb begin
    alu_start_d = (state_d == START);
    err_d       = (state_d == ERROR);
    display_d   = display_q;
    unique case (state_q)
      ENTER1:  display_d = num1_q;
      ENTER2:  display_d = num2_q;
      SHOW:    display_d = result_q;
      ERROR:   display_d = {DIGITS{4'hE}};
      default: display_d = display_q;
    endcase
  end

  assign num1      = num1_q;
  assign num2      = num2_q;
  assign operation = op_q;
  assign alu_start = alu_start_q;
  assign display   = display_q;
  assign state_o   = state_q;
  assign err       = err_q;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Self-checking bench for calc_ctrl_fsm (DIGITS=4, TIMEOUT_CYC=8).
// A transaction-level calculator model predicts the settled outputs after
// each key press; the bench also plays the ALU with configurable latency.
module tb_calc_ctrl_fsm;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] alu_res;
  logic        alu_done;
  logic        alu_err;
  logic [15:0] num1, num2, display;
  logic [3:0]  operation;
  logic        alu_start;
  logic [2:0]  state_o;
  logic        err;

  calc_ctrl_fsm #(.DIGITS(4), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .alu_res(alu_res), .alu_done(alu_done), .alu_err(alu_err),
    .num1(num1), .num2(num2), .operation(operation), .alu_start(alu_start),
    .display(display), .state_o(state_o), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ALU responder
  int          lat_cfg = 1;
  bit          en_cfg  = 1'b1;
  bit          err_cfg = 1'b0;
  logic [15:0] res_cfg = '0;
  int          resp_cnt = 0;
  int          start_cnt = 0;
  int          wait_cnt = 0;

  always @(negedge clk) begin
    alu_done = 1'b0;
    alu_err  = 1'b0;
    if (reset) begin
      resp_cnt = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          alu_done = 1'b1;
          alu_err  = err_cfg;
          alu_res  = res_cfg;
        end
      end
      if (alu_start) begin
        start_cnt++;
        if (en_cfg) resp_cnt = lat_cfg;
      end
      if (state_o == 3'd3) wait_cnt++;
    end
  end

  // Calculator model (state numbers are the documented debug codes)
  int          m_state;
  logic [15:0] m_num1, m_num2, m_result;
  int          m_cnt1, m_cnt2;
  logic [3:0]  m_op;
  int          m_starts = 0;

  task automatic m_clear();
    m_state = 0; m_num1 = '0; m_num2 = '0; m_result = '0;
    m_cnt1 = 0; m_cnt2 = 0; m_op = '0;
  endtask

  task automatic m_digit(inout logic [15:0] num, inout int cnt, input int d);
    if (cnt < 4 && !(d == 0 && cnt == 0)) begin
      num = (num << 4) | 16'(d);
      cnt++;
    end
  endtask

  // Outcome of one ALU transaction given the responder settings.
  task automatic m_compute(input bit chained, input logic [3:0] new_op);
    m_starts++;
    if (en_cfg && lat_cfg <= T && !err_cfg) begin
      m_result = res_cfg;
      if (chained) begin
        m_num1 = res_cfg; m_cnt1 = 4; m_op = new_op;
        m_num2 = '0; m_cnt2 = 0; m_state = 1;
      end else begin
        m_state = 4;
      end
    end else begin
      m_state = 5;
    end
  endtask

  task automatic m_press(input int c);
    case (m_state)
      0: if (c <= 9) m_digit(m_num1, m_cnt1, c);
         else if (c >= 12) begin m_op = 4'(c); m_num2 = '0; m_cnt2 = 0; m_state = 1; end
         else if (c == 11) begin m_num1 = '0; m_cnt1 = 0; end
      1: if (c <= 9) m_digit(m_num2, m_cnt2, c);
         else if (c == 10) m_compute(1'b0, 4'd0);
         else if (c == 11) m_clear();
         else begin
`ifdef CALC_CHAIN_EN
           if (m_cnt2 > 0) m_compute(1'b1, 4'(c));
           else m_op = 4'(c);
`else
           m_op = 4'(c);
`endif
         end
      4: if (c <= 9) begin
           m_num1 = 16'(c); m_cnt1 = (c != 0) ? 1 : 0;
           m_num2 = '0; m_cnt2 = 0; m_state = 0;
         end else if (c >= 12) begin
           m_num1 = m_result; m_cnt1 = 4; m_op = 4'(c);
           m_num2 = '0; m_cnt2 = 0; m_state = 1;
         end else if (c == 11) m_clear();
         else begin
           m_num1 = m_result; m_cnt1 = 4;
           m_compute(1'b0, 4'd0);
         end
      5: if (c == 11) m_clear();
      default: ;
    endcase
  endtask

  function automatic logic [15:0] m_display();
    case (m_state)
      0:       return m_num1;
      1:       return m_num2;
      4:       return m_result;
      5:       return 16'hEEEE;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_all();
    check_val("state", 32'(state_o), 32'(m_state));
    check_val("num1", 32'(num1), 32'(m_num1));
    check_val("num2", 32'(num2), 32'(m_num2));
    check_val("operation", 32'(operation), 32'(m_op));
    check_val("display", 32'(display), 32'(m_display()));
    check_val("err", 32'(err), 32'(m_state == 5));
    check_val("alu_start_idle", 32'(alu_start), 32'd0);
    check_val("start_count", 32'(start_cnt), 32'(m_starts));
  endtask

  task automatic press(input int c);
    @(negedge clk);
    key_code  = 4'(c);
    key_valid = 1'b1;
    repeat (2) @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom);
    repeat (20) @(negedge clk);
    m_press(c);
    check_all();
  endtask

  task automatic press_seq(input int a[]);
    foreach (a[i]) press(a[i]);
  endtask

  task automatic set_alu(input bit en, input int lat, input bit e,
                         input logic [15:0] r);
    en_cfg = en; lat_cfg = lat; err_cfg = e; res_cfg = r;
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = '0;
    alu_res = '0; alu_done = 1'b0; alu_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_clear();
    @(negedge clk);
    check_all();

    // 12 + 3 = with a 3-cycle ALU
    set_alu(1'b1, 3, 1'b0, 16'h0015);
    press_seq('{1, 2, 12, 3, 10});
    check_val("add_num1", 32'(num1), 32'h0012);
    check_val("add_num2", 32'(num2), 32'h0003);
    check_val("add_op", 32'(operation), 32'd12);
    check_val("add_starts", 32'(start_cnt), 32'd1);
    check_val("add_display", 32'(display), 32'h0015);
    check_val("add_state", 32'(state_o), 32'd4);

    // Continue from the result: * 2 =
    set_alu(1'b1, 2, 1'b0, 16'h0030);
    press_seq('{14, 2, 10});
    check_val("cont_num1", 32'(num1), 32'h0015);
    check_val("cont_op", 32'(operation), 32'd14);
    check_val("cont_starts", 32'(start_cnt), 32'd2);

    // Digit limit and leading zeros
    press_seq('{11, 1, 2, 3, 4, 5});
    check_val("limit_num1", 32'(num1), 32'h1234);
    press_seq('{11, 0, 0, 7, 1, 2, 3, 4});
    check_val("lead0_num1", 32'(num1), 32'h7123);

    // ALU error path
    set_alu(1'b1, 2, 1'b1, 16'h0000);
    press_seq('{15, 2, 10});
    check_val("aluerr_display", 32'(display), 32'hEEEE);
    check_val("aluerr_err", 32'(err), 32'd1);
    press_seq('{7, 12, 10});
    check_val("error_sticky", 32'(state_o), 32'd5);
    press(11);
    check_val("ac_clear", 32'({num1, num2, operation, display, err}), 32'd0);

    // Timeout: exactly T cycles in WAIT_ALU, then done on the last cycle
    set_alu(1'b0, 1, 1'b0, 16'h0000);
    press_seq('{1, 12, 2});
    wait_cnt = 0;
    press(10);
    check_val("tmo_wait_cycles", 32'(wait_cnt), 32'(T));
    check_val("tmo_state", 32'(state_o), 32'd5);
    press(11);
    set_alu(1'b1, T, 1'b0, 16'h0003);
    press_seq('{1, 12, 2});
    wait_cnt = 0;
    press(10);
    check_val("late_done_wait", 32'(wait_cnt), 32'(T));
    check_val("late_done_state", 32'(state_o), 32'd4);

    // Operator in ENTER2 after digits
    press(11);
    set_alu(1'b1, 2, 1'b0, 16'h0008);
    press_seq('{5, 12, 3, 13});
    check_val("opchg_op", 32'(operation), 32'd13);
    check_val("opchg_state", 32'(state_o), 32'd1);
`ifdef CALC_CHAIN_EN
    check_val("chain_num1", 32'(num1), 32'h0008);
`else
    check_val("nochain_num1", 32'(num1), 32'h0005);
`endif

    // Reset while a key is held: its release must be ignored
    @(negedge clk);
    key_code = 4'd5; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    repeat (2) @(negedge clk);
    key_valid = 1'b0;
    repeat (20) @(negedge clk);
    check_all();

    // Random key sequences
    for (int n = 0; n < 300; n++) begin
      int r;
      int c;
      r = $urandom_range(0, 99);
      if (r < 50)      c = $urandom_range(0, 9);
      else if (r < 70) c = $urandom_range(12, 15);
      else if (r < 88) c = 10;
      else             c = 11;
      set_alu($urandom_range(0, 9) != 0, $urandom_range(1, 11),
              $urandom_range(0, 9) == 0, 16'($urandom));
      press(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
